// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the iterative 32-bit divider in EX.
// Catches a DIV/DIVU in EX and latches its operands. It then holds the
// divider start level and stalls IF/ID/EX until the 64-bit result returns.
// After that it issues a single HI/LO write. A flush cancels an in-flight
// divide through a one-cycle annul, so the divider is free again before the
// next issue.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no divide in flight; issue when EX holds an unflushed DIV/DIVU
// BUSY  | divider running on latched operands, start held high
// DONE  | result latched, one-cycle HI/LO write unless flushed
// HOLD  | same DIV still parked in EX by another stall; never re-issued
// DRAIN | flushed divide being annulled for exactly one cycle

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_rs_i,
    input  logic [31:0] ex_rt_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BUSY  = 3'd1,
        S_DONE  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic issue;
    logic capture;

    // A divide is accepted only from IDLE and only if EX is not being flushed.
    assign issue = (state == S_IDLE) && ex_div_valid_i && !flush_i;

    // A flush in BUSY wins over a simultaneous ready, so the result is dropped.
    assign capture = (state == S_BUSY) && !flush_i && div_ready_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_nxt = S_DRAIN;
                end else if (div_ready_i) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (ex_stall_i && !flush_i) begin
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!ex_stall_i || flush_i) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode. Most outputs depend on state alone. The HI/LO write also
    // looks at the flush so that a flush arriving in DONE can still stop it.
    // The stall is raised combinationally on the issue cycle.
    always_comb begin
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        hilo_we_o   = 1'b0;
        stall_o     = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall_o = issue;
            end
            S_BUSY: begin
                div_start_o = 1'b1;
                stall_o     = 1'b1;
            end
            S_DONE: begin
                hilo_we_o = !flush_i;
            end
            S_HOLD: begin
                hilo_we_o = 1'b0;
            end
            S_DRAIN: begin
                div_annul_o = 1'b1;
            end
            default: begin
                div_start_o = 1'b0;
            end
        endcase
    end

    // Operand latch. After issue, the divider sees only these copies, so later
    // changes in EX have no effect on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_op1_o    <= 32'd0;
            div_op2_o    <= 32'd0;
            div_signed_o <= 1'b0;
        end else if (issue) begin
            div_op1_o    <= ex_rs_i;
            div_op2_o    <= ex_rt_i;
            div_signed_o <= ex_signed_i;
        end
    end

    // Result latch: remainder goes to HI, quotient to LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (capture) begin
            hi_o <= div_result_i[63:32];
            lo_o <= div_result_i[31:0];
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl. The bench plays the divider itself and
// supplies hand-computed {remainder, quotient} results at the documented
// ready cycles.

module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_signed_i;
    logic [31:0] ex_rs_i;
    logic [31:0] ex_rt_i;
    logic        ex_stall_i;
    logic        flush_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    div_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ex_div_valid_i(ex_div_valid_i),
        .ex_signed_i   (ex_signed_i),
        .ex_rs_i       (ex_rs_i),
        .ex_rt_i       (ex_rt_i),
        .ex_stall_i    (ex_stall_i),
        .flush_i       (flush_i),
        .div_ready_i   (div_ready_i),
        .div_result_i  (div_result_i),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .div_signed_o  (div_signed_o),
        .div_op1_o     (div_op1_o),
        .div_op2_o     (div_op2_o),
        .stall_o       (stall_o),
        .hilo_we_o     (hilo_we_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 time units after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a divide in EX in cycle t and check the issue stall. Returns in t+1.
    task automatic issue(input logic sgn, input logic [31:0] rs, input logic [31:0] rt);
        ex_div_valid_i = 1'b1;
        ex_signed_i    = sgn;
        ex_rs_i        = rs;
        ex_rt_i        = rt;
        #1;
        chk("issue_stall", {63'd0, stall_o}, 64'd1);
        chk("issue_nostart", {63'd0, div_start_o}, 64'd0);
        step();
    endtask

    // Stay in BUSY for n cycles; start and stall must both stay high throughout.
    task automatic busy_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("busy_start", {63'd0, div_start_o}, 64'd1);
            chk("busy_stall", {63'd0, stall_o}, 64'd1);
            step();
        end
    endtask

    // Raise ready with a result in the current BUSY cycle, then check DONE.
    task automatic finish(input logic [63:0] res);
        div_ready_i  = 1'b1;
        div_result_i = res;
        step();
        div_ready_i  = 1'b0;
        div_result_i = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("done_we", {63'd0, hilo_we_o}, 64'd1);
        chk("done_stall", {63'd0, stall_o}, 64'd0);
        chk("done_start", {63'd0, div_start_o}, 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        ex_div_valid_i = 1'b0;
        ex_signed_i    = 1'b0;
        ex_rs_i        = 32'd0;
        ex_rt_i        = 32'd0;
        ex_stall_i     = 1'b0;
        flush_i        = 1'b0;
        div_ready_i    = 1'b0;
        div_result_i   = 64'd0;
        step();
        step();
        #1;
        chk("rst_start", {63'd0, div_start_o}, 64'd0);
        chk("rst_annul", {63'd0, div_annul_o}, 64'd0);
        chk("rst_we", {63'd0, hilo_we_o}, 64'd0);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_op1", {32'd0, div_op1_o}, 64'd0);
        rst = 1'b0;
        step();

        // A stray ready while IDLE is ignored; a valid that is flushed is not issued.
        div_ready_i  = 1'b1;
        div_result_i = {32'h1111_1111, 32'h2222_2222};
        ex_div_valid_i = 1'b1;
        flush_i        = 1'b1;
        ex_rs_i        = 32'd77;
        #1;
        chk("flushed_issue_stall", {63'd0, stall_o}, 64'd0);
        step();
        div_ready_i    = 1'b0;
        ex_div_valid_i = 1'b0;
        flush_i        = 1'b0;
        #1;
        chk("idle_ready_start", {63'd0, div_start_o}, 64'd0);
        chk("idle_ready_we", {63'd0, hilo_we_o}, 64'd0);
        chk("idle_ready_lo", {32'd0, lo_o}, 64'd0);
        chk("flushed_issue_op1", {32'd0, div_op1_o}, 64'd0);
        step();

        // DIVU 100/7: stall over t..t+36, write at t+37, hi=2 lo=14.
        issue(1'b0, 32'd100, 32'd7);
        chk("divu_op1", {32'd0, div_op1_o}, 64'd100);
        chk("divu_op2", {32'd0, div_op2_o}, 64'd7);
        chk("divu_sgn", {63'd0, div_signed_o}, 64'd0);
        busy_cycles(35);
        finish({32'd2, 32'd14});
        chk("divu_hi", {32'd0, hi_o}, 64'd2);
        chk("divu_lo", {32'd0, lo_o}, 64'd14);
        ex_div_valid_i = 1'b0;
        step();
        #1;
        chk("divu_after_we", {63'd0, hilo_we_o}, 64'd0);
        chk("divu_after_stall", {63'd0, stall_o}, 64'd0);

        // DIV -7/2, with the dividend in EX changed mid-divide.
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        busy_cycles(2);
        ex_rs_i = 32'h0000_0055;
        ex_signed_i = 1'b0;
        busy_cycles(33);
        chk("div_op1_held", {32'd0, div_op1_o}, 64'hFFFF_FFF9);
        chk("div_sgn_held", {63'd0, div_signed_o}, 64'd1);
        finish({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("div_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
        chk("div_lo", {32'd0, lo_o}, 64'hFFFF_FFFD);
        ex_div_valid_i = 1'b0;
        step();

        // Divide by zero: ready at t+4, write at t+5, 0/0 stored.
        issue(1'b1, 32'd1234, 32'd0);
        busy_cycles(3);
        finish(64'd0);
        chk("dz_hi", {32'd0, hi_o}, 64'd0);
        chk("dz_lo", {32'd0, lo_o}, 64'd0);
        ex_div_valid_i = 1'b0;
        step();

        // Flush at t+10 together with ready: annul at t+11, no write, IDLE at t+12.
        issue(1'b0, 32'd500, 32'd9);
        busy_cycles(9);
        flush_i      = 1'b1;
        div_ready_i  = 1'b1;
        div_result_i = {32'h0000_00AA, 32'h0000_00BB};
        step();
        flush_i        = 1'b0;
        div_ready_i    = 1'b0;
        ex_div_valid_i = 1'b0;
        #1;
        chk("drain_annul", {63'd0, div_annul_o}, 64'd1);
        chk("drain_start", {63'd0, div_start_o}, 64'd0);
        chk("drain_we", {63'd0, hilo_we_o}, 64'd0);
        chk("drain_stall", {63'd0, stall_o}, 64'd0);
        step();
        #1;
        chk("post_drain_annul", {63'd0, div_annul_o}, 64'd0);
        chk("flush_hi_kept", {32'd0, hi_o}, 64'd0);
        chk("flush_lo_kept", {32'd0, lo_o}, 64'd0);
        issue(1'b0, 32'd9, 32'd3);
        busy_cycles(35);
        finish({32'd0, 32'd3});
        chk("d93_hi", {32'd0, hi_o}, 64'd0);
        chk("d93_lo", {32'd0, lo_o}, 64'd3);
        ex_div_valid_i = 1'b0;
        step();

        // External stall held 5 cycles over DONE: one write, HOLD, no re-issue.
        issue(1'b0, 32'd20, 32'd6);
        busy_cycles(35);
        ex_stall_i = 1'b1;
        finish({32'd2, 32'd3});
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("hold_we", {63'd0, hilo_we_o}, 64'd0);
            chk("hold_start", {63'd0, div_start_o}, 64'd0);
            chk("hold_stall", {63'd0, stall_o}, 64'd0);
        end
        ex_stall_i = 1'b0;
        step();
        ex_div_valid_i = 1'b0;
        #1;
        chk("hold_exit_start", {63'd0, div_start_o}, 64'd0);
        chk("hold_lo", {32'd0, lo_o}, 64'd3);
        step();
        #1;
        chk("hold_no_reissue", {63'd0, div_start_o}, 64'd0);

        // Flush during DONE suppresses the write.
        issue(1'b0, 32'd8, 32'd2);
        busy_cycles(35);
        div_ready_i  = 1'b1;
        div_result_i = {32'd0, 32'd4};
        step();
        div_ready_i = 1'b0;
        flush_i     = 1'b1;
        #1;
        chk("done_flush_we", {63'd0, hilo_we_o}, 64'd0);
        step();
        flush_i        = 1'b0;
        ex_div_valid_i = 1'b0;
        #1;
        chk("done_flush_idle", {63'd0, div_start_o}, 64'd0);
        step();

        // Reset at t+20 mid-divide, then DIVU 10/4 gives lo=2 hi=2.
        issue(1'b1, 32'd50, 32'd5);
        busy_cycles(19);
        rst            = 1'b1;
        ex_div_valid_i = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_start", {63'd0, div_start_o}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall_o}, 64'd0);
        chk("mid_rst_op1", {32'd0, div_op1_o}, 64'd0);
        chk("mid_rst_op2", {32'd0, div_op2_o}, 64'd0);
        chk("mid_rst_sgn", {63'd0, div_signed_o}, 64'd0);
        chk("mid_rst_lo", {32'd0, lo_o}, 64'd0);
        issue(1'b0, 32'd10, 32'd4);
        busy_cycles(35);
        finish({32'd2, 32'd2});
        chk("d104_hi", {32'd0, hi_o}, 64'd2);
        chk("d104_lo", {32'd0, lo_o}, 64'd2);
        ex_div_valid_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
